// File: rtl/mmio_int_ctrl.sv
// mmio_int_ctrl: memory-mapped, edge-triggered, prioritised interrupt controller.
// Ports: clock, reset_n (async, active low); CPU bus addr/w_data/w_en in,
//        r_data/hit out (combinational); irq_src[NUM_SRC] in; int_ack in;
//        int_req/int_vec out (registered).
// Window at BASE_ADDR: +0 CTRL(GIE), +1 MASK, +2 PEND(W1C), +3 EOI, +4+i VEC[i].
// Macro MMIO_INT_CTRL_SYNC_EN: two-flop synchronizer on irq_src before edge detect.
module mmio_int_ctrl #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         addr,
    input  logic [7:0]         w_data,
    input  logic               w_en,
    output logic [7:0]         r_data,
    output logic               hit,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               int_ack,
    output logic               int_req,
    output logic [7:0]         int_vec
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Edges after reset release before edge detection is trusted; covers
    // the synchronizer fill so a level held through reset is not an edge.
`ifdef MMIO_INT_CTRL_SYNC_EN
    localparam int ARM_EDGES = 3;
`else
    localparam int ARM_EDGES = 1;
`endif

    state_t             r_state;
    logic               r_gie;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_hist;
    logic [7:0]         r_vec [NUM_SRC];
    logic [2:0]         r_id;
    logic [7:0]         r_int_vec;
    logic               r_int_req;
    logic [1:0]         r_arm;

    logic [NUM_SRC-1:0] w_irq;

`ifdef MMIO_INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq = r_sync2;
`else
    assign w_irq = irq_src;
`endif

    // Address decode; bit 8 of the difference is the borrow (addr < base).
    logic [8:0] w_off9;
    logic [7:0] w_off;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_mask;
    logic       w_wr_pend;
    logic       w_eoi;

    assign w_off9    = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign w_off     = w_off9[7:0];
    assign hit       = !w_off9[8] && (w_off <= 8'(3 + NUM_SRC));
    assign w_wr      = w_en && hit;
    assign w_wr_ctrl = w_wr && (w_off == 8'd0);
    assign w_wr_mask = w_wr && (w_off == 8'd1);
    assign w_wr_pend = w_wr && (w_off == 8'd2);
    assign w_eoi     = w_wr && (w_off == 8'd3);

    logic               w_armed;
    logic [NUM_SRC-1:0] w_rise;

    assign w_armed = (r_arm == 2'(ARM_EDGES));
    assign w_rise  = w_armed ? (w_irq & ~r_hist) : '0;

    logic [NUM_SRC-1:0] w_id_oh;
    logic               w_take;
    logic               w_gie_n;
    logic [NUM_SRC-1:0] w_mask_n;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_pend_n;
    logic [NUM_SRC-1:0] w_elig;
    logic               w_withdraw;

    always_comb begin
        w_id_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_id_oh[i] = (r_id == 3'(i));
        end
    end

    assign w_take   = (r_state == REQ) && int_ack;
    assign w_gie_n  = w_wr_ctrl ? w_data[0] : r_gie;
    assign w_mask_n = w_wr_mask ? w_data[NUM_SRC-1:0] : r_mask;
    assign w_w1c    = w_wr_pend ? w_data[NUM_SRC-1:0] : '0;

    // New edges are ORed in last so a set beats a same-cycle clear.
    assign w_pend_n = (r_pend & ~w_w1c & ~({NUM_SRC{w_take}} & w_id_oh))
                    | w_rise;

    assign w_elig = r_gie ? (r_pend & r_mask) : '0;

    // Withdrawal looks at the values being written this cycle so the
    // request drops right after the store that disables it.
    assign w_withdraw = !w_gie_n
                     || !(|(w_mask_n & w_id_oh))
                     || !(|(w_pend_n & w_id_oh));

    logic [2:0] w_win;
    logic [7:0] w_win_vec;

    always_comb begin
        w_win     = 3'd0;
        w_win_vec = 8'h00;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win     = 3'(i);
                w_win_vec = r_vec[i];
            end
        end
    end

    logic [7:0] w_mask8;
    logic [7:0] w_pend8;
    logic [7:0] w_rd_vec;

    always_comb begin
        w_mask8 = 8'h00;
        w_pend8 = 8'h00;
        w_mask8[NUM_SRC-1:0] = r_mask;
        w_pend8[NUM_SRC-1:0] = r_pend;
    end

    always_comb begin
        w_rd_vec = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_off == 8'(4 + i)) begin
                w_rd_vec = r_vec[i];
            end
        end
    end

    always_comb begin
        r_data = 8'h00;
        if (hit) begin
            case (w_off)
                8'd0:    r_data = {7'd0, r_gie};
                8'd1:    r_data = w_mask8;
                8'd2:    r_data = w_pend8;
                8'd3:    r_data = {(r_state == SERVICE), 4'd0, r_id};
                default: r_data = w_rd_vec;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_gie     <= 1'b0;
            r_mask    <= '0;
            r_pend    <= '0;
            r_hist    <= '0;
            r_id      <= 3'd0;
            r_int_vec <= 8'h00;
            r_int_req <= 1'b0;
            r_arm     <= 2'd0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_vec[i] <= 8'h00;
            end
        end else begin
            r_hist <= w_irq;
            if (!w_armed) begin
                r_arm <= r_arm + 2'd1;
            end
            r_gie  <= w_gie_n;
            r_mask <= w_mask_n;
            r_pend <= w_pend_n;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_wr && (w_off == 8'(4 + i))) begin
                    r_vec[i] <= w_data;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_state   <= REQ;
                        r_int_req <= 1'b1;
                        r_int_vec <= w_win_vec;
                        r_id      <= w_win;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        r_state   <= SERVICE;
                        r_int_req <= 1'b0;
                    end else if (w_withdraw) begin
                        r_state   <= IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (w_eoi) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    assign int_req = r_int_req;
    assign int_vec = r_int_vec;

endmodule

// File: tb/tb_mmio_int_ctrl.sv
// tb_mmio_int_ctrl: directed table, hand sequences and randomized traffic
// for mmio_int_ctrl, compared against a behavioural reference model.
module tb_mmio_int_ctrl;

`ifdef MMIO_INT_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam int ST_IDLE = 0;
    localparam int ST_REQ  = 1;
    localparam int ST_SVC  = 2;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] addr    = 8'h00;
    logic [7:0] w_data  = 8'h00;
    logic       w_en    = 1'b0;
    logic [7:0] r_data;
    logic       hit;
    logic [3:0] irq_src = 4'h0;
    logic       int_ack = 1'b0;
    logic       int_req;
    logic [7:0] int_vec;

    always #5 clock = ~clock;

    mmio_int_ctrl #(
        .NUM_SRC   (4),
        .BASE_ADDR (8'hF0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (addr),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_data  (r_data),
        .hit     (hit),
        .irq_src (irq_src),
        .int_ack (int_ack),
        .int_req (int_req),
        .int_vec (int_vec)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file, pending set and a three-phase handshake.
    bit         m_gie;
    bit [3:0]   m_mask;
    bit [3:0]   m_pend;
    bit [3:0]   m_hist;
    bit [7:0]   m_vec [4];
    int         m_st;
    int         m_id;
    bit [7:0]   m_ivec;
    int         m_edges;
    bit [3:0]   m_dly [$];

    function automatic bit in_win(logic [7:0] a);
        return (a >= 8'hF0) && (a <= 8'hF7);
    endfunction

    task automatic model_reset();
        m_gie   = 0;
        m_mask  = 0;
        m_pend  = 0;
        m_hist  = 0;
        m_st    = ST_IDLE;
        m_id    = 0;
        m_ivec  = 0;
        m_edges = 0;
        for (int i = 0; i < 4; i++) m_vec[i] = 0;
        m_dly.delete();
        for (int i = 0; i < LAT; i++) m_dly.push_back(4'h0);
    endtask

    function automatic logic [7:0] model_read(logic [7:0] a);
        int off;
        if (!in_win(a)) return 8'h00;
        off = int'(a) - 'hF0;
        case (off)
            0: return {7'd0, m_gie};
            1: return {4'd0, m_mask};
            2: return {4'd0, m_pend};
            3: return {(m_st == ST_SVC), 4'd0, 3'(m_id)};
            default: return m_vec[off - 4];
        endcase
    endfunction

    task automatic model_step();
        bit [3:0] s, rise, w1c, mask_n, pend_n;
        bit       gie_n, wr;
        int       off;
        m_dly.push_back(irq_src);
        s = m_dly.pop_front();
        rise = (m_edges >= 1 + LAT) ? (s & ~m_hist) : 4'h0;
        m_hist = s;
        m_edges++;
        wr     = w_en && in_win(addr);
        off    = int'(addr) - 'hF0;
        gie_n  = (wr && off == 0) ? w_data[0] : m_gie;
        mask_n = (wr && off == 1) ? w_data[3:0] : m_mask;
        w1c    = (wr && off == 2) ? w_data[3:0] : 4'h0;
        pend_n = m_pend & ~w1c;
        if (m_st == ST_REQ && int_ack) pend_n[m_id] = 1'b0;
        pend_n = pend_n | rise;
        if (m_st == ST_IDLE) begin
            for (int i = 0; i < 4; i++) begin
                if (m_st == ST_IDLE && m_gie && m_pend[i] && m_mask[i]) begin
                    m_st   = ST_REQ;
                    m_id   = i;
                    m_ivec = m_vec[i];
                end
            end
        end else if (m_st == ST_REQ) begin
            if (int_ack) m_st = ST_SVC;
            else if (!gie_n || !mask_n[m_id] || !pend_n[m_id]) m_st = ST_IDLE;
        end else if (wr && off == 3) begin
            m_st = ST_IDLE;
        end
        if (wr && off >= 4) m_vec[off - 4] = w_data;
        m_gie  = gie_n;
        m_mask = mask_n;
        m_pend = pend_n;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("int_req", {7'd0, int_req}, {7'd0, (m_st == ST_REQ)});
        check("int_vec", int_vec, m_ivec);
        check("r_data", r_data, model_read(addr));
        check("hit", {7'd0, hit}, {7'd0, in_win(addr)});
    endtask

    task automatic drv(logic [7:0] a, logic [7:0] d, logic we,
                       logic [3:0] irq, logic ack);
        addr    = a;
        w_data  = d;
        w_en    = we;
        irq_src = irq;
        int_ack = ack;
    endtask

    task automatic idle();
        drv(8'h00, 8'h00, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        drv(a, d, 1'b1, 4'h0, 1'b0);
        tick();
        idle();
    endtask

    task automatic pulse(logic [3:0] irq);
        drv(8'h00, 8'h00, 1'b0, irq, 1'b0);
        tick();
        idle();
    endtask

    task automatic ack();
        drv(8'h00, 8'h00, 1'b0, 4'h0, 1'b1);
        tick();
        idle();
    endtask

    task automatic rdchk(string name, logic [7:0] a, logic [7:0] exp);
        drv(a, 8'h00, 1'b0, 4'h0, 1'b0);
        #1;
        check(name, r_data, exp);
    endtask

    task automatic wait_req(string name, int budget);
        int n = 0;
        idle();
        while (int_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, {7'd0, int_req}, 8'h01);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       we;
        logic [3:0] irq;
        logic       ack;
        logic       req;
        logic [7:0] vec;
        logic [7:0] rd;
    } row_t;

    row_t tbl [$];

    function automatic row_t mk(logic [7:0] a, logic [7:0] d, logic we,
                                logic [3:0] irq, logic ack, logic req,
                                logic [7:0] vec, logic [7:0] rd);
        row_t r;
        r.a = a; r.d = d; r.we = we; r.irq = irq; r.ack = ack;
        r.req = req; r.vec = vec; r.rd = rd;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] irq_r;
        logic [7:0] a, d;
        logic       we, ak;

        // Basic arbitration path, then ack and EOI.
        tbl.push_back(mk(8'hF6, 8'h40, 1, 4'h0, 0, 0, 8'h00, 8'h40));
        tbl.push_back(mk(8'hF1, 8'h04, 1, 4'h0, 0, 0, 8'h00, 8'h04));
        tbl.push_back(mk(8'hF0, 8'h01, 1, 4'h0, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(8'hF2, 8'h00, 0, 4'h4, 0, 0, 8'h00,
                         (LAT == 0) ? 8'h04 : 8'h00));
        for (int j = 1; j <= LAT; j++)
            tbl.push_back(mk(8'hF2, 8'h00, 0, 4'h0, 0, 0, 8'h00,
                             (j == LAT) ? 8'h04 : 8'h00));
        tbl.push_back(mk(8'hF2, 8'h00, 0, 4'h0, 0, 1, 8'h40, 8'h04));
        tbl.push_back(mk(8'hF3, 8'h00, 0, 4'h0, 1, 0, 8'h40, 8'h82));
        tbl.push_back(mk(8'hF2, 8'h00, 0, 4'h0, 0, 0, 8'h40, 8'h00));
        tbl.push_back(mk(8'hF3, 8'h00, 1, 4'h0, 0, 0, 8'h40, 8'h02));

        // Reset with irq_src[0] held high through release.
        model_reset();
        drv(8'h00, 8'h00, 1'b0, 4'h1, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst int_req", {7'd0, int_req}, 8'h00);
        check("rst int_vec", int_vec, 8'h00);
        for (int i = 0; i < 8; i++) begin
            addr = 8'hF0 + 8'(i);
            #1;
            check("rst r_data", r_data, 8'h00);
        end
        addr = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) tick();
        rdchk("held level no edge", 8'hF2, 8'h00);
        idle();
        tick();

        foreach (tbl[i]) begin
            drv(tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].irq, tbl[i].ack);
            tick();
            check("tbl req", {7'd0, int_req}, {7'd0, tbl[i].req});
            check("tbl vec", int_vec, tbl[i].vec);
            check("tbl rd", r_data, tbl[i].rd);
        end
        idle();

        // Two sources together: lower index first, then the other.
        wr(8'hF5, 8'h20);
        wr(8'hF7, 8'h60);
        wr(8'hF1, 8'h0A);
        pulse(4'hA);
        wait_req("dual req1", 8);
        check("dual vec1", int_vec, 8'h20);
        wr(8'hF5, 8'h77);
        check("vec write in REQ", int_vec, 8'h20);
        ack();
        wr(8'hF3, 8'h00);
        wait_req("dual req2", 8);
        check("dual vec2", int_vec, 8'h60);
        ack();
        wr(8'hF3, 8'h00);

        // Withdrawal by GIE and re-assertion.
        pulse(4'h8);
        wait_req("wd req", 8);
        wr(8'hF0, 8'h00);
        check("wd int_req", {7'd0, int_req}, 8'h00);
        rdchk("wd pend kept", 8'hF2, 8'h08);
        wr(8'hF0, 8'h01);
        wait_req("wd reassert", 8);
        check("wd vec", int_vec, 8'h60);
        ack();
        wr(8'hF3, 8'h00);

        // No nesting during SERVICE.
        wr(8'hF4, 8'h10);
        wr(8'hF1, 8'h0F);
        pulse(4'h1);
        wait_req("svc req", 8);
        check("svc vec", int_vec, 8'h10);
        ack();
        pulse(4'h1);
        repeat (2 + LAT) tick();
        check("svc no nest", {7'd0, int_req}, 8'h00);
        rdchk("svc pend", 8'hF2, 8'h01);
        rdchk("svc eoi read", 8'hF3, 8'h80);
        wr(8'hF3, 8'h00);
        check("eoi idle", {7'd0, int_req}, 8'h00);
        tick();
        check("eoi re-req", {7'd0, int_req}, 8'h01);
        ack();

        // Set beats same-cycle W1C, then async reset mid-SERVICE.
        pulse(4'h4);
        tick();
        drv(8'hF2, 8'h04, 1'b1, 4'h4, 1'b0);
        tick();
        idle();
        repeat (LAT) tick();
        rdchk("set beats w1c", 8'hF2, 8'h04);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async int_req", {7'd0, int_req}, 8'h00);
        check("async int_vec", int_vec, 8'h00);
        check("async pend", r_data, 8'h00);
        rdchk("async eoi", 8'hF3, 8'h00);
        rdchk("async vec0", 8'hF4, 8'h00);
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic against the model.
        irq_r = 4'h0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 80) a = 8'hF0 + 8'($urandom_range(0, 7));
            else a = 8'($urandom);
            we = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom);
            if (a == 8'hF0) d[0] = ($urandom_range(0, 3) != 0);
            irq_r = irq_r ^ (4'($urandom) & 4'($urandom));
            if (m_st == ST_REQ) ak = ($urandom_range(0, 2) == 0);
            else ak = ($urandom_range(0, 15) == 0);
            drv(a, d, we, irq_r, ak);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
